// File: rtl/vc_pkg.sv
// Shared definitions for the virtual-channel mux datapath.
package vc_pkg;

  typedef enum logic [0:0] {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_e;

  localparam int DEFAULT_DATA_WIDTH = 6;
  localparam int DEFAULT_NUM_VC     = 2;

  // Width of a VC index; never narrower than one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vc_fifo.sv
// Per-VC input FIFO: head is presented combinationally, flags come from the
// registered count only, dropped writes set a sticky overflow flag.
module vc_fifo
  import vc_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset_L,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  full,
  output logic                  empty,
  output logic                  overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic                  push_ok, pop_ok;

  // Accept/pop decisions and next pointer/count state.
  always_comb begin
    pop_ok   = pop && (count_q != '0);
    push_ok  = push && ((count_q != CW'(FIFO_DEPTH)) || pop_ok);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q | (push & ~push_ok);
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer, count and sticky-overflow registers.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage array; contents are don't-care while the count says empty.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

  assign dout     = mem_q[rd_ptr_q];
  assign full     = (count_q == CW'(FIFO_DEPTH));
  assign empty    = (count_q == '0);
  assign overflow = ovf_q;

endmodule

// File: rtl/vc_arb_mux.sv
// N-VC multiplexer: per-VC FIFOs, fixed-priority or round-robin arbiter,
// registered output stage with backpressure and source-VC tag.
module vc_arb_mux
  import vc_pkg::*;
#(
  parameter int NUM_VC     = DEFAULT_NUM_VC,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int FIFO_DEPTH = 4,
  parameter int ARB_MODE   = 0
) (
  input  logic                           clk,
  input  logic                           reset_L,
  input  logic [NUM_VC-1:0]              valid_in,
  input  logic [NUM_VC*DATA_WIDTH-1:0]   data_in,
  input  logic                           ready_out,
  output logic [DATA_WIDTH-1:0]          data_out,
  output logic                           valid_out,
  output logic [id_width(NUM_VC)-1:0]    vc_id_out,
  output logic [NUM_VC-1:0]              fifo_full,
  output logic [NUM_VC-1:0]              fifo_empty,
  output logic [NUM_VC-1:0]              overflow_err
);

  localparam int IDW = id_width(NUM_VC);

  logic [DATA_WIDTH-1:0] head [NUM_VC];
  logic [NUM_VC-1:0]     grant;
  logic                  grant_any;
  logic [IDW-1:0]        grant_idx;
  logic                  slot_free;
  logic [IDW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [IDW-1:0]        vc_q, vc_d;
  logic                  valid_q, valid_d;

  for (genvar i = 0; i < NUM_VC; i++) begin : g_fifo
    vc_fifo #(
      .DATA_WIDTH(DATA_WIDTH),
      .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
      .clk     (clk),
      .reset_L (reset_L),
      .push    (valid_in[i]),
      .pop     (grant[i]),
      .din     (data_in[i*DATA_WIDTH +: DATA_WIDTH]),
      .dout    (head[i]),
      .full    (fifo_full[i]),
      .empty   (fifo_empty[i]),
      .overflow(overflow_err[i])
    );
  end

  // Arbiter: one-hot grant to a non-empty FIFO whenever the output slot is free.
  always_comb begin : p_arb
    logic [IDW-1:0] idx;
    grant     = '0;
    grant_any = 1'b0;
    grant_idx = '0;
    idx       = '0;
    slot_free = !valid_q || ready_out;
    if (slot_free) begin
      if (ARB_MODE == int'(ARB_RR)) begin
        for (int unsigned off = 0; off < NUM_VC; off++) begin
          idx = IDW'((32'(rr_ptr_q) + off) % 32'(NUM_VC));
          if (!grant_any && !fifo_empty[idx]) begin
            grant_any = 1'b1;
            grant_idx = idx;
          end
        end
      end else begin
        // Descending scan so the last hit, the lowest index, wins.
        for (int unsigned k = NUM_VC; k > 0; k--) begin
          idx = IDW'(k - 1);
          if (!fifo_empty[idx]) begin
            grant_any = 1'b1;
            grant_idx = idx;
          end
        end
      end
      if (grant_any) grant[grant_idx] = 1'b1;
    end
  end

  // Output stage and round-robin pointer next state.
  always_comb begin
    data_d   = data_q;
    vc_d     = vc_q;
    valid_d  = valid_q;
    rr_ptr_d = rr_ptr_q;
    if (grant_any) begin
      data_d   = head[grant_idx];
      vc_d     = grant_idx;
      valid_d  = 1'b1;
      rr_ptr_d = IDW'((32'(grant_idx) + 32'd1) % 32'(NUM_VC));
    end else if (slot_free && ready_out) begin
      valid_d = 1'b0;
    end
  end

  // Output and arbitration registers.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      data_q   <= '0;
      vc_q     <= '0;
      valid_q  <= 1'b0;
      rr_ptr_q <= '0;
    end else begin
      data_q   <= data_d;
      vc_q     <= vc_d;
      valid_q  <= valid_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign data_out  = data_q;
  assign vc_id_out = vc_q;
  assign valid_out = valid_q;

endmodule

// File: tb/tb_vc_arb_mux.sv
// Directed bench: table of per-cycle vectors plus hand sequences for
// round-robin order, overflow and asynchronous reset.
module tb_vc_arb_mux;

  logic        clk = 1'b0;
  logic        reset_L;
  logic [1:0]  valid_in;
  logic [11:0] data_in;
  logic        ready_out;

  logic [5:0] f_data, r_data;
  logic       f_valid, r_valid;
  logic [0:0] f_vc, r_vc;
  logic [1:0] f_full, r_full, f_empty, r_empty, f_ovf, r_ovf;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  vc_arb_mux #(.NUM_VC(2), .DATA_WIDTH(6), .FIFO_DEPTH(4), .ARB_MODE(0)) dut_fp (
    .clk(clk), .reset_L(reset_L), .valid_in(valid_in), .data_in(data_in),
    .ready_out(ready_out), .data_out(f_data), .valid_out(f_valid),
    .vc_id_out(f_vc), .fifo_full(f_full), .fifo_empty(f_empty),
    .overflow_err(f_ovf)
  );

  vc_arb_mux #(.NUM_VC(2), .DATA_WIDTH(6), .FIFO_DEPTH(4), .ARB_MODE(1)) dut_rr (
    .clk(clk), .reset_L(reset_L), .valid_in(valid_in), .data_in(data_in),
    .ready_out(ready_out), .data_out(r_data), .valid_out(r_valid),
    .vc_id_out(r_vc), .fifo_full(r_full), .fifo_empty(r_empty),
    .overflow_err(r_ovf)
  );

  typedef struct {
    logic [1:0] vin;
    logic [5:0] d1;
    logic [5:0] d0;
    logic       rdy;
    logic       ev;
    logic [5:0] ed;
    logic       evc;
    logic [1:0] eemp;
  } vec_t;

  vec_t tbl [12];

  function automatic vec_t mk(input logic [1:0] vin, input logic [5:0] d1,
                              input logic [5:0] d0, input logic rdy,
                              input logic ev, input logic [5:0] ed,
                              input logic evc, input logic [1:0] eemp);
    vec_t v;
    v.vin = vin; v.d1 = d1; v.d0 = d0; v.rdy = rdy;
    v.ev = ev; v.ed = ed; v.evc = evc; v.eemp = eemp;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [5:0] cap_r [8];
  logic [0:0] cap_rv [8];
  logic [5:0] cap_f [8];
  int nr, nf;
  logic [5:0] exp_r [6];
  logic [0:0] exp_rv [6];
  logic [5:0] exp_f [6];

  initial begin
    // vin, d1, d0, rdy -> valid, data, vc, empty (sampled after the edge)
    tbl[0]  = mk(2'b00, 6'h00, 6'h00, 1'b1, 1'b0, 6'h00, 1'b0, 2'b11);
    tbl[1]  = mk(2'b11, 6'h30, 6'h34, 1'b1, 1'b0, 6'h00, 1'b0, 2'b00);
    tbl[2]  = mk(2'b00, 6'h00, 6'h00, 1'b1, 1'b1, 6'h34, 1'b0, 2'b01);
    tbl[3]  = mk(2'b00, 6'h00, 6'h00, 1'b1, 1'b1, 6'h30, 1'b1, 2'b11);
    tbl[4]  = mk(2'b00, 6'h00, 6'h00, 1'b1, 1'b0, 6'h30, 1'b1, 2'b11);
    tbl[5]  = mk(2'b01, 6'h00, 6'h2E, 1'b1, 1'b0, 6'h30, 1'b1, 2'b10);
    tbl[6]  = mk(2'b00, 6'h00, 6'h00, 1'b0, 1'b1, 6'h2E, 1'b0, 2'b11);
    tbl[7]  = mk(2'b10, 6'h11, 6'h00, 1'b0, 1'b1, 6'h2E, 1'b0, 2'b01);
    tbl[8]  = mk(2'b00, 6'h00, 6'h00, 1'b0, 1'b1, 6'h2E, 1'b0, 2'b01);
    tbl[9]  = mk(2'b00, 6'h00, 6'h00, 1'b0, 1'b1, 6'h2E, 1'b0, 2'b01);
    tbl[10] = mk(2'b00, 6'h00, 6'h00, 1'b1, 1'b1, 6'h11, 1'b1, 2'b11);
    tbl[11] = mk(2'b00, 6'h00, 6'h00, 1'b1, 1'b0, 6'h11, 1'b1, 2'b11);

    exp_r  = '{6'h21, 6'h07, 6'h22, 6'h08, 6'h23, 6'h09};
    exp_rv = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    exp_f  = '{6'h21, 6'h22, 6'h23, 6'h07, 6'h08, 6'h09};

    // Reset
    reset_L   = 1'b0;
    valid_in  = '0;
    data_in   = '0;
    ready_out = 1'b0;
    #2;
    chk("rst_valid", f_valid, 1'b0);
    chk("rst_data", f_data, 6'h00);
    chk("rst_empty", f_empty, 2'b11);
    chk("rst_full", f_full, 2'b00);
    chk("rst_ovf", f_ovf, 2'b00);
    #3;
    reset_L = 1'b1;
    #1;

    // Table-driven: idle, fixed priority, backpressure
    for (int i = 0; i < 12; i++) begin
      valid_in  = tbl[i].vin;
      data_in   = {tbl[i].d1, tbl[i].d0};
      ready_out = tbl[i].rdy;
      step();
      chk($sformatf("tbl%0d_valid", i), f_valid, tbl[i].ev);
      chk($sformatf("tbl%0d_data", i), f_data, tbl[i].ed);
      chk($sformatf("tbl%0d_vc", i), f_vc, tbl[i].evc);
      chk($sformatf("tbl%0d_empty", i), f_empty, tbl[i].eemp);
      chk($sformatf("tbl%0d_full", i), f_full, 2'b00);
    end

    // Round-robin vs fixed order with three words per VC
    nr = 0; nf = 0;
    ready_out = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (c < 3) begin
        valid_in = 2'b11;
        data_in  = {6'h07 + 6'(c), 6'h21 + 6'(c)};
      end else begin
        valid_in = 2'b00;
        data_in  = '0;
      end
      step();
      if (r_valid && nr < 8) begin cap_r[nr] = r_data; cap_rv[nr] = r_vc; nr++; end
      if (f_valid && nf < 8) begin cap_f[nf] = f_data; nf++; end
    end
    chk("rr_count", nr, 6);
    chk("fp_count", nf, 6);
    for (int i = 0; i < 6; i++) begin
      if (i < nr) begin
        chk($sformatf("rr_data%0d", i), cap_r[i], exp_r[i]);
        chk($sformatf("rr_vc%0d", i), cap_rv[i], exp_rv[i]);
      end
      if (i < nf) chk($sformatf("fp_data%0d", i), cap_f[i], exp_f[i]);
    end

    // Overflow on VC1 with output stalled
    ready_out = 1'b0;
    for (int c = 0; c < 6; c++) begin
      valid_in = 2'b10;
      data_in  = {6'h10 + 6'(c), 6'h00};
      step();
      if (c == 4) begin
        chk("ovf_full4", f_full, 2'b10);
        chk("ovf_none4", f_ovf, 2'b00);
      end
      if (c == 5) begin
        chk("ovf_full5", f_full, 2'b10);
        chk("ovf_set", f_ovf, 2'b10);
        chk("ovf_rr_set", r_ovf, 2'b10);
        chk("ovf_hold_valid", f_valid, 1'b1);
        chk("ovf_hold_data", f_data, 6'h10);
      end
    end
    valid_in  = 2'b00;
    data_in   = '0;
    ready_out = 1'b1;
    nf = 0;
    for (int c = 0; c < 8; c++) begin
      if (f_valid && nf < 8) begin cap_f[nf] = f_data; nf++; end
      step();
    end
    chk("drain_count", nf, 5);
    for (int i = 0; i < 5; i++)
      if (i < nf) chk($sformatf("drain%0d", i), cap_f[i], 6'h10 + 6'(i));
    chk("ovf_sticky", f_ovf, 2'b10);
    chk("drain_empty", f_empty, 2'b11);

    // Asynchronous reset mid-operation
    ready_out = 1'b0;
    valid_in  = 2'b11;
    data_in   = {6'h02, 6'h01};
    step();
    step();
    valid_in = 2'b00;
    data_in  = '0;
    #3;
    chk("pre_rst_valid", f_valid, 1'b1);
    chk("pre_rst_empty", f_empty, 2'b00);
    reset_L = 1'b0;
    #1;
    chk("arst_valid", f_valid, 1'b0);
    chk("arst_empty", f_empty, 2'b11);
    chk("arst_ovf", f_ovf, 2'b00);
    chk("arst_rr_ovf", r_ovf, 2'b00);
    chk("arst_data", f_data, 6'h00);
    chk("arst_vc", f_vc, 1'b0);
    #2;
    reset_L = 1'b1;
    step();
    valid_in  = 2'b01;
    data_in   = {6'h00, 6'h3A};
    ready_out = 1'b1;
    step();
    valid_in = 2'b00;
    data_in  = '0;
    chk("post_push_valid", f_valid, 1'b0);
    chk("post_push_empty", f_empty, 2'b10);
    step();
    chk("post_valid", f_valid, 1'b1);
    chk("post_data", f_data, 6'h3A);
    chk("post_vc", f_vc, 1'b0);
    chk("post_rr_data", r_data, 6'h3A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vc_arb_mux.md
Name: vc_arb_mux

Overview:
- Parametrised N-virtual-channel multiplexer with per-channel input buffering.
- Each VC writes into its own small FIFO. An arbiter (fixed-priority or round-robin) selects one non-empty FIFO per cycle into a registered output stage.
- The output stage honours downstream backpressure and tags each word with its source VC.
- Generalises the 2-VC, 6-bit, unbuffered mux used on the VC datapath.

Parameters:
- NUM_VC, 2, number of virtual channels (2..8).
- DATA_WIDTH, 6, payload width per VC.
- FIFO_DEPTH, 4, entries per VC FIFO (power of 2, >=2).
- ARB_MODE, 0, 0 = fixed priority (VC0 highest), 1 = round-robin.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset_L  in  1  asynchronous, active-low reset; clears all state immediately.
- valid_in  in  NUM_VC  per-VC write strobe.
- data_in  in  NUM_VC*DATA_WIDTH  flattened payload; VCi occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- ready_out  in  1  downstream accepts data_out this cycle.
- data_out  out  DATA_WIDTH  registered output payload.
- valid_out  out  1  data_out holds a valid word.
- vc_id_out  out  $clog2(NUM_VC) (min 1)  source VC of data_out.
- fifo_full  out  NUM_VC  per-VC FIFO occupancy == FIFO_DEPTH.
- fifo_empty  out  NUM_VC  per-VC FIFO occupancy == 0.
- overflow_err  out  NUM_VC  sticky; set when a write to VCi is dropped.

Behaviour:
- Reset (async, reset_L=0):
  - All FIFO pointers and counts = 0.
  - fifo_empty = all 1s; fifo_full = 0; overflow_err = 0.
  - data_out = 0; valid_out = 0; vc_id_out = 0.
  - Round-robin pointer = 0.
  - Takes effect mid-transfer without waiting for clk; buffered data is discarded.
- Push to VCi:
  - Accepted when valid_in[i] && (count_i < FIFO_DEPTH || pop_i this cycle).
  - A push into a full FIFO that is popped in the same cycle is accepted; count is unchanged.
  - valid_in[i] && full && !pop_i: word dropped, overflow_err[i] <= 1, held until reset.
- Output slot free when !valid_out || ready_out.
- Grant (combinational, one-hot, only when slot free and at least one FIFO non-empty):
  - ARB_MODE=0: lowest-index non-empty VC.
  - ARB_MODE=1: search starts at rr_ptr, wraps modulo NUM_VC; after a grant to VCk, rr_ptr <= (k+1) mod NUM_VC.
  - rr_ptr is unchanged when there is no grant.
- On grant to VCk:
  - Pop head of FIFO k.
  - data_out <= head, vc_id_out <= k, valid_out <= 1.
- Slot free, no grant: valid_out <= 0 if ready_out; data_out and vc_id_out hold their last value.
- valid_out && !ready_out: data_out, vc_id_out and valid_out all hold; no pop, no rr_ptr change.
- Latency:
  - Word written at edge t into an empty FIFO with an idle output appears with valid_out=1 after edge t+1 (one cycle in FIFO).
  - Throughput 1 word/cycle aggregate when ready_out is held high.
- Push and pop on the same VC in the same cycle: both occur; count unchanged. An empty FIFO cannot be popped in the same cycle as its first push (no bypass).
- FIFO pointers are log2(FIFO_DEPTH) bits and wrap naturally. Count is log2(FIFO_DEPTH)+1 bits.
- fifo_full and fifo_empty are decoded from the registered count only; there is no combinational path from valid_in or ready_out.

Decomposition:
- Shared package vc_pkg:
  - ARB_FIXED=0, ARB_RR=1 constants.
  - Default DATA_WIDTH=6 and NUM_VC=2 constants.
- Sub-module vc_fifo (DATA_WIDTH, FIFO_DEPTH):
  - Ports: clk, reset_L, push, pop, din, dout (head, combinational), full, empty, overflow.
  - Instantiated NUM_VC times via generate.
- Arbiter and output register remain in vc_arb_mux.

Test Plan:
- Reset then idle: reset_L=0 for 5 time units, then 1 with valid_in=0 -> valid_out=0, fifo_empty=2'b11, data_out=0 every cycle.
- Fixed priority, ARB_MODE=0: single cycle with VC0=0x34 and VC1=0x30 both valid, ready_out=1 -> outputs 0x34/vc0, then 0x30/vc1 on consecutive cycles.
- Round-robin, ARB_MODE=1: VC0 pushes 0x21,0x22,0x23 and VC1 pushes 0x07,0x08,0x09 -> output order 0x21,0x07,0x22,0x08,0x23,0x09.
- Backpressure: ready_out=0 with 0x2E pending -> data_out=0x2E and valid_out=1 held for 3 cycles, FIFO counts unchanged. Raising ready_out resumes draining.
- Overflow, FIFO_DEPTH=4, ready_out=0: 6 pushes on VC1 (0x10..0x15) -> fifo_full[1]=1 after 4 accepted (0x10 moves to the output register, so the 6th word is dropped); overflow_err[1]=1 and stays set. Draining yields 0x10..0x14 only.
- Reset mid-operation: reset_L=0 asynchronously between edges while both FIFOs are non-empty and valid_out=1 -> valid_out=0, fifo_empty=all 1s, overflow_err=0 immediately. After release, a new word 0x3A on VC0 appears 1 edge after its push.
